// File: rtl/pixel_write_sink_pkg.sv
// Shared screen geometry, FSM encoding and pixel entry type for the pixel-write path.
// Drawers, the write sink and the framebuffer all take their constants from here.
package pixel_write_sink_pkg;

  localparam int WIDTH      = 160;
  localparam int HEIGHT     = 120;
  localparam int COLOUR_W   = 18;
  localparam int ADDR_W     = 15;
  localparam int FIFO_DEPTH = 4;
  localparam int PIXELS     = WIDTH * HEIGHT;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_CLEAR      = 2'd1;
  localparam logic [1:0] ST_CLEAR_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE       = 2'd3;

  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic [COLOUR_W-1:0] colour;
  } pixel_t;

  // Row-major linear address; the multiply by a constant reduces to shifts and adds.
  function automatic logic [ADDR_W-1:0] pixel_addr(input logic [7:0] x, input logic [6:0] y);
    return ADDR_W'(y) * ADDR_W'(WIDTH) + ADDR_W'(x);
  endfunction

endpackage

// File: rtl/pixel_write_sink_fifo.sv
// Small synchronous FIFO of {addr, colour} entries with same-cycle push and pop.
// A push into a full FIFO is honoured only when a pop happens in the same cycle.
module pixel_fifo
  import pixel_write_sink_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  pixel_t                   push_data,
  input  logic                     pop,
  output pixel_t                   head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  pixel_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     count_q;
  logic               do_push;
  logic               do_pop;

  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: storage has no reset; validity is tracked by count_q, so clearing the array would only cost flops.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/pixel_write_sink.sv
// Receiving end of the vga_x/vga_y/vga_colour/vga_write pixel interface: bounds check,
// address conversion, buffering, full-screen clear engine and a granted framebuffer write port.
module pixel_write_sink
  import pixel_write_sink_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic [7:0]          vga_x,
  input  logic [6:0]          vga_y,
  input  logic [COLOUR_W-1:0] vga_colour,
  input  logic                vga_write,
  output logic                ready,
  input  logic                start_clear,
  input  logic [COLOUR_W-1:0] clear_colour,
  output logic                clear_done,
  output logic [ADDR_W-1:0]   fb_addr,
  output logic [COLOUR_W-1:0] fb_data,
  output logic                fb_we,
  input  logic                fb_grant,
  output logic                idle,
  output logic                overflow,
  output logic [15:0]         drop_count,
  input  logic                clear_stats
);

  localparam int                CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [7:0]        X_LIMIT   = 8'(WIDTH);
  localparam logic [6:0]        Y_LIMIT   = 7'(HEIGHT);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic [ADDR_W-1:0]   clr_cnt;
  logic [ADDR_W-1:0]   clr_cnt_nxt;
  logic [COLOUR_W-1:0] clr_colour;

  logic [ADDR_W-1:0]   pix_addr;
  logic                in_range;
  logic                pixel_ok;
  logic                reg_free;
  logic                load;
  logic [ADDR_W-1:0]   load_addr;
  logic [COLOUR_W-1:0] load_data;
  logic                pop;
  logic                bypass;
  logic                push;
  logic                drop_range;
  logic                drop_full;

  pixel_t              head;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CNT_W-1:0]    fifo_count;

  assign pix_addr = pixel_addr(vga_x, vga_y);
  assign in_range = (vga_x < X_LIMIT) && (vga_y < Y_LIMIT);
  assign pixel_ok = vga_write && in_range;
  assign reg_free = !fb_we || fb_grant;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    load        = 1'b0;
    load_addr   = '0;
    load_data   = '0;
    pop         = 1'b0;
    bypass      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start_clear) begin
          state_nxt   = ST_CLEAR;
          clr_cnt_nxt = '0;
        end
      end
      ST_CLEAR: begin
        if (reg_free) begin
          load        = 1'b1;
          load_addr   = clr_cnt;
          load_data   = clr_colour;
          clr_cnt_nxt = clr_cnt + 1'b1;
          if (clr_cnt == LAST_ADDR) state_nxt = ST_CLEAR_WAIT;
        end
      end
      ST_CLEAR_WAIT: begin
        if (fb_we && fb_grant) state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    // The FIFO is frozen while the clear owns the port; buffered pixels land after it.
    if (state != ST_CLEAR && reg_free) begin
      if (!fifo_empty) begin
        pop       = 1'b1;
        load      = 1'b1;
        load_addr = head.addr;
        load_data = head.colour;
      end else if (pixel_ok) begin
        bypass    = 1'b1;
        load      = 1'b1;
        load_addr = pix_addr;
        load_data = vga_colour;
      end
    end
  end

  assign push       = pixel_ok && !bypass && (!fifo_full || pop);
  assign drop_range = vga_write && !in_range;
  assign drop_full  = pixel_ok && fifo_full && !pop;

  pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data ('{addr: pix_addr, colour: vga_colour}),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      clr_cnt    <= '0;
      clr_colour <= '0;
      fb_we      <= 1'b0;
      fb_addr    <= '0;
      fb_data    <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
      if (state == ST_IDLE && start_clear) clr_colour <= clear_colour;

      // Address and data only move when the slot is free, keeping them stable under a pending request.
      if (load) begin
        fb_we   <= 1'b1;
        fb_addr <= load_addr;
        fb_data <= load_data;
      end else if (fb_grant) begin
        fb_we   <= 1'b0;
      end

      if (clear_stats) begin
        overflow   <= 1'b0;
        drop_count <= '0;
      end else begin
        if (drop_full) overflow <= 1'b1;
        if ((drop_range || drop_full) && drop_count != 16'hFFFF)
          drop_count <= drop_count + 1'b1;
      end
    end
  end

  assign clear_done = (state == ST_DONE);
  assign ready      = (fifo_count != CNT_W'(FIFO_DEPTH));
  assign idle       = (state == ST_IDLE) && fifo_empty && !fb_we;

endmodule

// File: tb/tb_pixel_write_sink.sv
// Directed bench for pixel_write_sink: a queue of expected framebuffer writes, derived from
// the pixel/clear rules, is checked against every granted write, plus literal spot checks.
module tb_pixel_write_sink;
  import pixel_write_sink_pkg::*;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic [7:0]          vga_x = '0;
  logic [6:0]          vga_y = '0;
  logic [COLOUR_W-1:0] vga_colour = '0;
  logic                vga_write = 1'b0;
  logic                ready;
  logic                start_clear = 1'b0;
  logic [COLOUR_W-1:0] clear_colour = '0;
  logic                clear_done;
  logic [ADDR_W-1:0]   fb_addr;
  logic [COLOUR_W-1:0] fb_data;
  logic                fb_we;
  logic                fb_grant = 1'b0;
  logic                idle;
  logic                overflow;
  logic [15:0]         drop_count;
  logic                clear_stats = 1'b0;

  pixel_write_sink dut (
    .clock        (clock),
    .reset        (reset),
    .vga_x        (vga_x),
    .vga_y        (vga_y),
    .vga_colour   (vga_colour),
    .vga_write    (vga_write),
    .ready        (ready),
    .start_clear  (start_clear),
    .clear_colour (clear_colour),
    .clear_done   (clear_done),
    .fb_addr      (fb_addr),
    .fb_data      (fb_data),
    .fb_we        (fb_we),
    .fb_grant     (fb_grant),
    .idle         (idle),
    .overflow     (overflow),
    .drop_count   (drop_count),
    .clear_stats  (clear_stats)
  );

  always #5 clock = ~clock;

  int cycle_cnt = 0;
  always @(posedge clock) cycle_cnt++;

  int total  = 0;
  int passed = 0;

  typedef struct { int addr; int data; } wr_t;
  wr_t exp_q[$];

  int              last_grant_addr  = -1;
  int              last_grant_cycle = -1;
  logic            hold = 1'b0;
  logic [ADDR_W-1:0]   hold_addr;
  logic [COLOUR_W-1:0] hold_data;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cycle_cnt);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_px(input int x, input int y, input int c);
    vga_x      = 8'(x);
    vga_y      = 7'(y);
    vga_colour = COLOUR_W'(c);
    vga_write  = 1'b1;
  endtask

  task automatic expect_px(input int x, input int y, input int c);
    wr_t e;
    e.addr = y * 160 + x;
    e.data = c;
    exp_q.push_back(e);
  endtask

  task automatic expect_clear(input int c);
    wr_t e;
    for (int k = 0; k < 160 * 120; k++) begin
      e.addr = k;
      e.data = c;
      exp_q.push_back(e);
    end
  endtask

  // Write monitor: every granted write must be the next expected one, and a pending request must hold still.
  always @(negedge clock) begin
    wr_t e;
    if (reset) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("hold_we", fb_we, 1);
        check("hold_addr", fb_addr, hold_addr);
        check("hold_data", fb_data, hold_data);
      end
      if (fb_we && fb_grant) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write at cycle %0d",
                   fb_addr, fb_data, cycle_cnt);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", fb_addr, e.addr);
          check("wr_data", fb_data, e.data);
        end
        last_grant_addr  = int'(fb_addr);
        last_grant_cycle = cycle_cnt;
        hold = 1'b0;
      end else if (fb_we) begin
        hold      = 1'b1;
        hold_addr = fb_addr;
        hold_data = fb_data;
      end else begin
        hold = 1'b0;
      end
    end
  end

  initial begin
    int c0;
    int done_cnt;

    // Reset state
    tick(); tick();
    check("rst_fb_we", fb_we, 0);
    check("rst_fb_addr", fb_addr, 0);
    check("rst_fb_data", fb_data, 0);
    check("rst_clear_done", clear_done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_drop_count", drop_count, 0);
    check("rst_ready", ready, 1);
    check("rst_idle", idle, 1);
    reset = 1'b0;
    tick();

    // 1: bypass, one-cycle latency
    fb_grant = 1'b1;
    drive_px(5, 2, 'h3FFFF);
    expect_px(5, 2, 'h3FFFF);
    tick();
    vga_write = 1'b0;
    check("t1_we", fb_we, 1);
    check("t1_addr", fb_addr, 325);
    check("t1_data", fb_data, 'h3FFFF);
    tick();
    check("t1_we_gone", fb_we, 0);
    check("t1_idle", idle, 1);

    // 2: back-pressure, overflow on the sixth pixel
    fb_grant = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive_px(i, 0, 16 + i);
      if (i < 5) expect_px(i, 0, 16 + i);
      tick();
    end
    vga_write = 1'b0;
    check("t2_overflow", overflow, 1);
    check("t2_drop_count", drop_count, 1);
    check("t2_ready", ready, 0);
    check("t2_head_addr", fb_addr, 0);
    fb_grant = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    check("t2_drained", exp_q.size(), 0);
    tick();
    check("t2_idle", idle, 1);
    check("t2_ready_back", ready, 1);

    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    check("stats_cleared_cnt", drop_count, 0);
    check("stats_cleared_ovf", overflow, 0);

    // 3: out-of-range pixels and the last valid pixel
    drive_px(160, 0, 1);
    tick();
    drive_px(0, 120, 2);
    tick();
    drive_px(159, 119, 'h155);
    expect_px(159, 119, 'h155);
    tick();
    vga_write = 1'b0;
    check("t3_drop_count", drop_count, 2);
    check("t3_overflow", overflow, 0);
    check("t3_last_addr", fb_addr, 19199);
    drive_px(200, 0, 3);
    clear_stats = 1'b1;
    tick();
    vga_write   = 1'b0;
    clear_stats = 1'b0;
    check("t3_stats_priority", drop_count, 0);
    tick();
    check("t3_idle", idle, 1);

    // 4 + 5: full clear with a pixel written during it and an ignored second start
    c0 = cycle_cnt;
    clear_colour = '0;
    start_clear  = 1'b1;
    expect_clear(0);
    tick();
    start_clear = 1'b0;
    drive_px(10, 0, 7);
    expect_px(10, 0, 7);
    tick();
    vga_write = 1'b0;
    check("t4_busy", idle, 0);
    clear_colour = 'h3FFFF;
    start_clear  = 1'b1;
    tick();
    start_clear = 1'b0;
    for (int i = 0; i < 20100 && !clear_done; i++) tick();
    check("t4_done_seen", clear_done, 1);
    if (clear_done) begin
      check("t4_done_cycle", cycle_cnt - c0, 19202);
      check("t4_last_clear_addr", last_grant_addr, 19199);
      check("t4_done_after_grant", last_grant_cycle, cycle_cnt - 1);
      check("t5_px_addr", fb_addr, 10);
      check("t5_px_data", fb_data, 7);
      tick();
      check("t4_done_pulse", clear_done, 0);
      check("t4_idle_after", idle, 1);
    end
    check("t5_queue_empty", exp_q.size(), 0);

    // 6: reset mid-clear with three pixels pending
    clear_colour = COLOUR_W'(5);
    start_clear  = 1'b1;
    expect_clear(5);
    tick();
    start_clear = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    for (int i = 1; i <= 3; i++) begin
      drive_px(i, 1, 40 + i);
      tick();
    end
    vga_write = 1'b0;
    check("t6_ready_3", ready, 1);
    check("t6_busy", idle, 0);
    reset = 1'b1;
    exp_q.delete();
    tick();
    check("t6_fb_we", fb_we, 0);
    check("t6_idle", idle, 1);
    check("t6_ready", ready, 1);
    check("t6_fb_addr", fb_addr, 0);
    reset = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (clear_done) done_cnt++;
    end
    check("t6_no_clear_done", done_cnt, 0);
    check("t6_idle_after", idle, 1);
    check("t6_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
